// File: rtl/ramcu_pkg.sv
// Shared defaults and helpers for the multi-channel RAM control unit.
package ramcu_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_NUM_CH     = 2;
  localparam int MAX_CH         = 8;

  localparam int CH_W = (DEF_NUM_CH > 1) ? $clog2(DEF_NUM_CH) : 1;

  function automatic logic [MAX_CH-1:0] idx2onehot(input logic [2:0] idx);
    return MAX_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/ramcu_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted channel.
module rr_arbiter
  import ramcu_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  if (N == 1) begin : g_single
    assign gnt = req & {N{~rst}};
  end else begin : g_multi
    localparam int PW = $clog2(N);

    logic [PW-1:0] last_q, last_d;
    logic [PW-1:0] win_idx;
    logic          found;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
      found   = 1'b0;
      win_idx = '0;
      for (int k = 1; k <= N; k++) begin
        if (!found && req[(int'(last_q) + k) % N]) begin
          found   = 1'b1;
          win_idx = PW'((int'(last_q) + k) % N);
        end
      end
    end

    always_comb begin
      gnt    = (found && !rst) ? N'(idx2onehot(3'(win_idx))) : '0;
      last_d = found ? win_idx : last_q;
    end

    // Reset to the top index so the first search begins at channel 0.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= PW'(N - 1);
      else     last_q <= last_d;
    end
  end

endmodule

// File: rtl/ramcu_mp.sv
// Multi-channel RAM control unit: NUM_CH requesters share one synchronous
// RAM through a round-robin arbiter; reads return on a registered bus.
module ramcu_mp
  import ramcu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH-1:0]            we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
  output logic [NUM_CH-1:0]            gnt,
  output logic [NUM_CH-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         busy
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  acc;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_CH-1:0]     rvalid_q, rvalid_d;
  logic                  busy_q, busy_d;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  // Grant is one-hot, so an OR-style select picks the winning channel's fields.
  always_comb begin
    acc       = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        acc       = 1'b1;
        sel_we    = we[i];
        sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    in_range = {1'b0, sel_addr} < (ADDR_WIDTH + 1)'(RAM_DEPTH);
    rd_word  = in_range ? mem[sel_addr] : '0;
    rdata_d  = (acc && !sel_we) ? rd_word : rdata_q;
    rvalid_d = (acc && !sel_we) ? gnt : '0;
    busy_d   = |(req & ~gnt);
  end

  // NOTE: the memory array has no reset; contents survive rst and map to plain RAM.
  always_ff @(posedge clk) begin
    if (acc && sel_we && in_range) mem[sel_addr] <= sel_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_ramcu_mp.sv
// Directed self-checking bench for ramcu_mp (2 channels, RAM_DEPTH=200).
module tb_ramcu_mp;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NC = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   req;
  logic [NC-1:0]   we;
  logic [NC*AW-1:0] addr;
  logic [NC*DW-1:0] wdata;
  logic [NC-1:0]   gnt;
  logic [NC-1:0]   rvalid;
  logic [DW-1:0]   rdata;
  logic            busy;

  int n_checks = 0;
  int n_errs   = 0;

  ramcu_mp #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RAM_DEPTH (200),
    .NUM_CH    (NC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .gnt   (gnt),
    .rvalid(rvalid),
    .rdata (rdata),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic r, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[ch]          = r;
    we[ch]           = w;
    addr[ch*AW +: AW] = a;
    wdata[ch*DW +: DW] = d;
  endtask

  // Step past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    #3;
    check("reset_rdata",  32'(rdata),  32'h0);
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_gnt",    32'(gnt),    32'h0);
    check("reset_busy",   32'(busy),   32'h0);
    tick(); tick();
    rst = 1'b0;

    // ch0 writes A5 @10, then ch1 reads @10
    set_ch(0, 1'b1, 1'b1, 8'h10, 8'hA5);
    #1 check("wr_gnt", 32'(gnt), 32'h1);
    tick();
    set_ch(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_ch(1, 1'b1, 1'b0, 8'h10, 8'h00);
    #1 check("rd_gnt", 32'(gnt), 32'h2);
    check("wr_no_rvalid", 32'(rvalid), 32'h0);
    tick();
    // ch1 writes 5A @20 while the read data is visible
    set_ch(1, 1'b1, 1'b1, 8'h20, 8'h5A);
    check("rd_rvalid", 32'(rvalid), 32'h2);
    check("rd_rdata",  32'(rdata),  32'hA5);
    check("rd_busy",   32'(busy),   32'h0);
    tick();

    // full contention, both reading: pointer last=1 so ch0 goes first
    set_ch(0, 1'b1, 1'b0, 8'h10, 8'h00);
    set_ch(1, 1'b1, 1'b0, 8'h20, 8'h00);
    for (int k = 0; k < 6; k++) begin
      #1 check($sformatf("cont_gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k > 0) begin
        check($sformatf("cont_rvalid%0d", k), 32'(rvalid), (k % 2 == 1) ? 32'h1 : 32'h2);
        check($sformatf("cont_rdata%0d", k),  32'(rdata),  (k % 2 == 1) ? 32'hA5 : 32'h5A);
        check($sformatf("cont_busy%0d", k),   32'(busy),   32'h1);
      end
      tick();
    end
    req = '0;
    check("cont_last_rvalid", 32'(rvalid), 32'h2);
    check("cont_last_rdata",  32'(rdata),  32'h5A);
    check("cont_last_busy",   32'(busy),   32'h1);

    // asynchronous reset in the middle of a cycle
    #2;
    req = 2'b11;
    rst = 1'b1;
    #1;
    check("async_rdata",  32'(rdata),  32'h0);
    check("async_rvalid", 32'(rvalid), 32'h0);
    check("async_gnt",    32'(gnt),    32'h0);
    check("async_busy",   32'(busy),   32'h0);
    tick();
    req = '0;
    rst = 1'b0;

    // write 3C then read back from the same channel
    set_ch(0, 1'b1, 1'b1, 8'h30, 8'h3C);
    #1 check("raw_wr_gnt", 32'(gnt), 32'h1);
    tick();
    set_ch(0, 1'b1, 1'b0, 8'h30, 8'h00);
    #1 check("raw_rd_gnt", 32'(gnt), 32'h1);
    tick();
    set_ch(0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("raw_rvalid", 32'(rvalid), 32'h1);
    check("raw_rdata",  32'(rdata),  32'h3C);

    // out of range: preload 77 @50, write FF @250, read 250 then 50
    set_ch(1, 1'b1, 1'b1, 8'd50, 8'h77);
    tick();
    set_ch(1, 1'b1, 1'b1, 8'd250, 8'hFF);
    tick();
    set_ch(1, 1'b1, 1'b0, 8'd250, 8'h00);
    #1 check("oor_rd_gnt", 32'(gnt), 32'h2);
    tick();
    set_ch(1, 1'b1, 1'b0, 8'd50, 8'h00);
    check("oor_rvalid", 32'(rvalid), 32'h2);
    check("oor_rdata",  32'(rdata),  32'h00);
    tick();
    set_ch(1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("alias_rvalid", 32'(rvalid), 32'h2);
    check("alias_rdata",  32'(rdata),  32'h77);
    tick();
    check("idle_rvalid", 32'(rvalid), 32'h0);
    check("idle_rdata_hold", 32'(rdata), 32'h77);

    // ch0 read accepted, then a second read killed by reset before its edge
    set_ch(0, 1'b1, 1'b0, 8'h30, 8'h00);
    tick();
    #1 check("pend_rvalid", 32'(rvalid), 32'h1);
    check("pend_rdata", 32'(rdata), 32'h3C);
    check("pend_gnt", 32'(gnt), 32'h1);
    #1 rst = 1'b1;
    #1 check("pend_rst_rvalid", 32'(rvalid), 32'h0);
    check("pend_rst_gnt", 32'(gnt), 32'h0);
    tick();
    rst = 1'b0;
    set_ch(1, 1'b1, 1'b0, 8'd50, 8'h00);
    check("post_rst_rvalid", 32'(rvalid), 32'h0);
    check("post_rst_rdata",  32'(rdata),  32'h0);
    #1 check("post_rst_gnt", 32'(gnt), 32'h1);
    tick();
    check("post_rst_rd_rvalid", 32'(rvalid), 32'h1);
    check("post_rst_rd_rdata",  32'(rdata),  32'h3C);
    check("post_rst_next_gnt",  32'(gnt),    32'h2);
    check("post_rst_busy",      32'(busy),   32'h1);
    tick();
    req = '0;
    check("final_rvalid", 32'(rvalid), 32'h2);
    check("final_rdata",  32'(rdata),  32'h77);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/ramcu_mp.md
Name: ramcu_mp

Overview:
Parametrised multi-channel successor to the single-port RAM control unit. NUM_CH independent requesters share one synchronous RAM array through a round-robin arbiter with a req/gnt handshake. Read data comes back on a dedicated registered bus with a per-channel valid strobe, so there is no tri-state bus. The block sits between CPU-side and DMA-side masters and the on-chip memory.

Parameters:
DATA_WIDTH, 8, word size in bits
ADDR_WIDTH, 8, address width in bits
RAM_DEPTH, 1<<ADDR_WIDTH, number of words implemented (must be <= 2^ADDR_WIDTH)
NUM_CH, 2, number of requesting channels (1..8)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req  in  NUM_CH  per-channel request, held until granted
we  in  NUM_CH  per-channel write(1)/read(0) qualifier, valid with req
addr  in  NUM_CH*ADDR_WIDTH  channel i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
wdata  in  NUM_CH*DATA_WIDTH  channel i write data at bits [i*DATA_WIDTH +: DATA_WIDTH]
gnt  out  NUM_CH  one-hot grant, combinational from req and arbiter pointer
rvalid  out  NUM_CH  one-hot read-data-valid strobe
rdata  out  DATA_WIDTH  registered read data, shared by all channels
busy  out  1  registered; high while any req was pending at the last edge and was not granted

Behaviour:
- Reset (async, rst=1): rdata=0, rvalid=0, busy=0, arbiter pointer set so channel 0 has highest priority. Memory contents are not reset. gnt=0 while rst is high.
- Arbitration: at most one gnt bit per cycle. The search starts at channel (last_granted+1) mod NUM_CH and picks the first channel with req=1. The pointer updates only on a cycle with a grant. gnt[i]=0 whenever req[i]=0.
- Transfer: a transfer is accepted at the rising edge where gnt[i]=1. A requester that sees gnt drops or changes req/addr/wdata for the next cycle. If a requester keeps req high after a grant, that is a new transfer.
- Write (we[i]=1): mem[addr_i] <= wdata_i at the accept edge. rvalid stays 0.
- Read (we[i]=0): rdata <= mem[addr_i] at the accept edge. rvalid[i]=1 for exactly the following cycle. Read latency is 1 cycle from accept.
- rdata holds its last value when no read occurs. rvalid returns to 0 unless a back-to-back read is accepted.
- Back-to-back: one transfer per cycle sustained. Alternating channels under full contention each get a grant every NUM_CH cycles. Starvation is impossible.
- Read-after-write, same address, consecutive cycles: the read returns the newly written data.
- Out of range (addr >= RAM_DEPTH): a write is dropped. A read returns 0 with rvalid asserted normally.
- busy: registered OR of (req & ~gnt) at each edge.
- Reset mid-operation: a pending rvalid is cleared immediately. A transfer granted in the same cycle as reset assertion has no effect.
- NUM_CH=1: the arbiter degenerates to gnt=req and the pointer is unused.

Decomposition:
- Package ramcu_pkg: default DATA_WIDTH/ADDR_WIDTH/NUM_CH constants; a localparam CH_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1 for pointer width; an idx2onehot function.
- Sub-module rr_arbiter (parameter N; ports clk, rst, req[N], gnt[N]): owns the pointer and masked-priority logic. ramcu_mp holds the memory array, mux, rdata/rvalid registers and busy.

Test Plan:
- Reset with rst=1 mid-cycle, asynchronous to clk -> rdata=0, rvalid=0, gnt=0, busy=0 immediately.
- Ch0 writes 0xA5 to addr 0x10; one cycle later ch1 reads 0x10 -> gnt[1] on the read cycle, rvalid=2'b10 and rdata=0xA5 on the next cycle.
- req=2'b11 held for 6 cycles after reset, both reading distinct addresses -> gnt sequence 01,10,01,10,01,10; rvalid follows one cycle later; busy=1 throughout.
- Write 0x3C then read the same address on consecutive cycles from the same channel -> rdata=0x3C one cycle after the read grant.
- RAM_DEPTH=200: write 0xFF to addr 250, then read 250 -> rvalid=1 and rdata=0x00; mem[250 mod 200] is unchanged.
- Read granted, then rst pulsed before the next edge -> rvalid never asserts; after release the first grant goes to ch0 even though ch0 was the last granted.
